// File: rtl/act_skew_loader.sv
// act_skew_loader: reads NUM_VEC three-byte activation vectors from the
// shared synchronous-read data memory after weight preload finishes and
// feeds them to the 3x3 systolic array rows with a diagonal skew (row r
// trails row 0 by r cycles).
//
// Optional build macro ACT_PAD_ZERO_EN: when defined, each act_row_r reads
// 8'h00 whenever its act_valid bit is low; when undefined, rows hold their
// last issued value and consumers qualify with act_valid.
module act_skew_loader #(
    parameter int NUM_VEC   = 3,
    parameter int BASE_ADDR = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] q,
    output logic [5:0] addr,
    output logic [7:0] act_row_0,
    output logic [7:0] act_row_1,
    output logic [7:0] act_row_2,
    output logic [2:0] act_valid,
    output logic       busy,
    output logic       is_done_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH1,
        FETCH2,
        ISSUE,
        DRAIN
    } state_t;

    state_t     state;
    state_t     state_next;

    // Five bits cover NUM_VEC up to 18 plus the one-past-last value.
    logic [4:0] vec_cnt;
    logic       drain_cnt;
    logic       armed;

    logic [7:0] hold0;
    logic [7:0] hold1;
    logic [7:0] skew1;
    logic [7:0] skew2a;
    logic [7:0] skew2b;
    logic [7:0] row0_q;
    logic [7:0] row1_q;
    logic [7:0] row2_q;

    logic       skew1_v;
    logic       skew2a_v;
    logic       skew2b_v;
    logic       skew2a_last;
    logic       skew2b_last;
    logic [2:0] valid_q;
    logic       done_q;

    logic       last_vec;
    logic       issue;
    logic [6:0] vec_base;

    assign last_vec = (vec_cnt == 5'(NUM_VEC - 1));
    assign issue    = (state == ISSUE);
    assign vec_base = 7'(BASE_ADDR) + 7'(vec_cnt) * 7'd3;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and memory address; IDLE parks on BASE_ADDR so that the
    // idle cycle doubles as the element-0 fetch of vector 0, and ISSUE
    // prefetches element 0 of the following vector.
    always_comb begin
        state_next = state;
        addr       = 6'(BASE_ADDR);
        case (state)
            IDLE: begin
                if (en && armed) begin
                    state_next = FETCH1;
                end
            end
            FETCH1: begin
                addr       = 6'(vec_base + 7'd1);
                state_next = FETCH2;
            end
            FETCH2: begin
                addr       = 6'(vec_base + 7'd2);
                state_next = ISSUE;
            end
            ISSUE: begin
                if (last_vec) begin
                    addr       = 6'(BASE_ADDR);
                    state_next = DRAIN;
                end else begin
                    addr       = 6'(vec_base + 7'd3);
                    state_next = FETCH1;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counters, start arming, and capture of memory data into hold regs.
    // A level-high en triggers only once: armed re-arms only after en is
    // seen low while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_cnt   <= '0;
            drain_cnt <= 1'b0;
            armed     <= 1'b1;
            hold0     <= '0;
            hold1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    vec_cnt   <= '0;
                    drain_cnt <= 1'b0;
                    if (en && armed) begin
                        armed <= 1'b0;
                    end else if (!en) begin
                        armed <= 1'b1;
                    end
                end
                FETCH1: begin
                    hold0 <= q;
                end
                FETCH2: begin
                    hold1 <= q;
                end
                ISSUE: begin
                    vec_cnt <= vec_cnt + 5'd1;
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Skew pipeline: row 0 loads at ISSUE, row 1 one edge later, row 2 two
    // edges later. Valid and last-vector flags travel alongside the data
    // so every row sees the same bubble pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            row0_q      <= '0;
            row1_q      <= '0;
            row2_q      <= '0;
            skew1       <= '0;
            skew2a      <= '0;
            skew2b      <= '0;
            skew1_v     <= 1'b0;
            skew2a_v    <= 1'b0;
            skew2b_v    <= 1'b0;
            skew2a_last <= 1'b0;
            skew2b_last <= 1'b0;
            valid_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            if (issue) begin
                row0_q <= hold0;
                skew1  <= hold1;
                skew2a <= q;
            end
            if (skew1_v) begin
                row1_q <= skew1;
            end
            if (skew2a_v) begin
                skew2b <= skew2a;
            end
            if (skew2b_v) begin
                row2_q <= skew2b;
            end
            skew1_v     <= issue;
            skew2a_v    <= issue;
            skew2a_last <= issue && last_vec;
            skew2b_v    <= skew2a_v;
            skew2b_last <= skew2a_v && skew2a_last;
            valid_q[0]  <= issue;
            valid_q[1]  <= skew1_v;
            valid_q[2]  <= skew2b_v;
            done_q      <= skew2b_v && skew2b_last;
        end
    end

    // busy covers the FSM run plus the final row-2 cycle, which lands
    // after the FSM has already returned to IDLE.
    assign busy      = (state != IDLE) || done_q;
    assign is_done_o = done_q;
    assign act_valid = valid_q;

`ifdef ACT_PAD_ZERO_EN
    assign act_row_0 = valid_q[0] ? row0_q : 8'h00;
    assign act_row_1 = valid_q[1] ? row1_q : 8'h00;
    assign act_row_2 = valid_q[2] ? row2_q : 8'h00;
`else
    assign act_row_0 = row0_q;
    assign act_row_1 = row1_q;
    assign act_row_2 = row2_q;
`endif

endmodule
